// File: rtl/decode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : decode_ctrl
// Purpose  : Single-issue instruction decode/sequence controller driving the
//            register-file strobes and execute unit. Optional execute timeout
//            is enabled with `define DECODE_CTRL_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module decode_ctrl (
  input  logic        clk,
  input  logic        Clear_n,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic        alu_done,
  output logic [3:0]  Aaddr,
  output logic [3:0]  Baddr,
  output logic [3:0]  Caddr,
  output logic        Load,
  output logic        Clear,
  output logic [3:0]  alu_op,
  output logic        busy,
  output logic        err
);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_CLR  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_CLR    = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] instr_q;
  logic [3:0]  aaddr_q, baddr_q, caddr_q, alu_op_q;
  logic        load_q, clear_q;
  logic        accept;
  logic        tmo_hit;

  assign accept = (state_q == S_IDLE) && instr_valid;

`ifdef DECODE_CTRL_TIMEOUT_EN
  logic [4:0] tmo_cnt_q, tmo_cnt_d;
  logic       err_q, err_d;

  // Counter holds the number of EXEC cycles already completed, so 15 marks the 16th.
  assign tmo_hit = (tmo_cnt_q == 5'd15);

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    err_d     = err_q;
    if (state_q == S_DECODE) begin
      tmo_cnt_d = 5'd0;
    end else if (state_q == S_EXEC) begin
      tmo_cnt_d = tmo_cnt_q + 5'd1;
      if (!alu_done && tmo_hit) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge Clear_n) begin
    if (!Clear_n) begin
      tmo_cnt_q <= 5'd0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
    end
  end

  assign err = err_q;
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (instr_valid) state_d = S_DECODE;
      S_DECODE: begin
        case (instr_q[15:12])
          OP_NOP:  state_d = S_IDLE;
          OP_CLR:  state_d = S_CLR;
          OP_HALT: state_d = S_HALT;
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        if (alu_done)     state_d = S_WB;
        else if (tmo_hit) state_d = S_IDLE;
      end
      S_WB:     state_d = S_IDLE;
      S_CLR:    state_d = S_IDLE;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Clear_n) begin
    if (!Clear_n) begin
      state_q  <= S_IDLE;
      instr_q  <= 16'd0;
      aaddr_q  <= 4'd0;
      baddr_q  <= 4'd0;
      caddr_q  <= 4'd0;
      alu_op_q <= 4'd0;
      load_q   <= 1'b0;
      clear_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        instr_q <= instr;
      end
      if (state_q == S_DECODE) begin
        aaddr_q  <= instr_q[7:4];
        baddr_q  <= instr_q[3:0];
        caddr_q  <= instr_q[11:8];
        alu_op_q <= instr_q[15:12];
      end
      // Strobes track the state being entered so they coincide with WB/CLR.
      load_q  <= (state_d == S_WB);
      clear_q <= (state_d == S_CLR);
    end
  end

  assign instr_ready = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign Aaddr       = aaddr_q;
  assign Baddr       = baddr_q;
  assign Caddr       = caddr_q;
  assign alu_op      = alu_op_q;
  assign Load        = load_q;
  assign Clear       = clear_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_ctrl
// Purpose  : Directed self-checking bench for decode_ctrl with a write-back
//            scoreboard. Timeout scenarios run when DECODE_CTRL_TIMEOUT_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_ctrl;

  logic        clk = 1'b0;
  logic        Clear_n = 1'b0;
  logic [15:0] instr = 16'd0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic        alu_done = 1'b1;
  logic [3:0]  Aaddr, Baddr, Caddr, alu_op;
  logic        Load, Clear, busy, err;

  typedef struct {
    logic       is_clr;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
    logic [3:0] op;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  decode_ctrl dut (
    .clk         (clk),
    .Clear_n     (Clear_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .alu_done    (alu_done),
    .Aaddr       (Aaddr),
    .Baddr       (Baddr),
    .Caddr       (Caddr),
    .Load        (Load),
    .Clear       (Clear),
    .alu_op      (alu_op),
    .busy        (busy),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents one instruction for one cycle; returns in the DECODE cycle.
  task automatic issue(input logic [15:0] w, input bit expect_wb);
    exp_t e;
    @(negedge clk);
    chk("ready_before_accept", {15'd0, instr_ready}, 16'd1);
    instr       = w;
    instr_valid = 1'b1;
    e.is_clr = (w[15:12] == 4'hE);
    e.a  = w[7:4];
    e.b  = w[3:0];
    e.c  = w[11:8];
    e.op = w[15:12];
    if (e.is_clr || expect_wb) sb_q.push_back(e);
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  // Every Load/Clear strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (Clear_n && (Load || Clear)) begin
      chk("load_clear_exclusive", {15'd0, Load & Clear}, 16'd0);
      if (sb_q.size() == 0) begin
        chk("unexpected_strobe", {14'd0, Load, Clear}, 16'd0);
      end else begin
        e = sb_q.pop_front();
        chk("strobe_kind", {14'd0, Load, Clear}, e.is_clr ? 16'd1 : 16'd2);
        if (!e.is_clr) begin
          chk("wb_fields", {Aaddr, Baddr, Caddr, alu_op}, {e.a, e.b, e.c, e.op});
        end
      end
    end
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_addrs", {Aaddr, Baddr, Caddr, alu_op}, 16'h0000);
    chk("rst_ctrl", {12'd0, Load, Clear, err, busy}, 16'd0);
    Clear_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {15'd0, instr_ready}, 16'd1);

    // Basic op, alu_done already high
    issue(16'h3A51, 1'b1);
    chk("basic_decode_busy", {14'd0, busy, instr_ready}, 16'd2);
    chk("basic_decode_load", {15'd0, Load}, 16'd0);
    @(negedge clk);
    chk("basic_fields", {Aaddr, Baddr, Caddr, alu_op}, 16'h51A3);
    chk("basic_exec_load", {15'd0, Load}, 16'd0);
    @(negedge clk);
    chk("basic_load_latency", {15'd0, Load}, 16'd1);
    @(negedge clk);
    chk("basic_load_single", {14'd0, Load, instr_ready}, 16'd1);

    // NOP
    issue(16'h0123, 1'b0);
    chk("nop_busy", {15'd0, busy}, 16'd1);
    @(negedge clk);
    chk("nop_idle", {13'd0, busy, instr_ready, Load}, 16'd2);
    chk("nop_fields", {Aaddr, Baddr, Caddr, alu_op}, 16'h2310);

    // CLR
    issue(16'hE000, 1'b0);
    chk("clr_decode", {14'd0, Clear, Load}, 16'd0);
    @(negedge clk);
    chk("clr_pulse", {14'd0, Clear, Load}, 16'd2);
    @(negedge clk);
    chk("clr_done", {14'd0, Clear, busy}, 16'd0);
    chk("clr_fields", {Aaddr, Baddr, Caddr, alu_op}, 16'h000E);

    // Stall in EXEC
    alu_done = 1'b0;
    issue(16'h2100, 1'b1);
    for (int i = 0; i < 10; i++) begin
      chk("stall_hold", {14'd0, instr_ready, Load}, 16'd0);
      @(negedge clk);
    end
    alu_done = 1'b1;
    @(negedge clk);
    chk("stall_load", {15'd0, Load}, 16'd1);
    @(negedge clk);
    chk("stall_done", {14'd0, Load, instr_ready}, 16'd1);

    // HALT ignores further instructions until reset
    issue(16'hF000, 1'b0);
    instr       = 16'h1111;
    instr_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("halt_stuck", {12'd0, busy, instr_ready, Load, Clear}, 16'h8);
      chk("halt_fields", {Aaddr, alu_op}, 16'h000F);
    end
    instr_valid = 1'b0;
    #2 Clear_n = 1'b0;
    #1 chk("halt_reset", {14'd0, busy, instr_ready}, 16'd1);
    @(negedge clk);
    Clear_n = 1'b1;
    @(negedge clk);
    chk("halt_release_ready", {15'd0, instr_ready}, 16'd1);

    // Reset during the write-back cycle
    issue(16'h4C72, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("midwb_load", {15'd0, Load}, 16'd1);
    #2 Clear_n = 1'b0;
    #1 chk("midwb_ctrl", {12'd0, Load, Clear, err, busy}, 16'd0);
    chk("midwb_fields", {Aaddr, Baddr, Caddr, alu_op}, 16'h0000);
    @(negedge clk);
    Clear_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midwb_no_load", {14'd0, Load, instr_ready}, 16'd1);
    end

`ifdef DECODE_CTRL_TIMEOUT_EN
    // Timeout after 16 EXEC cycles without alu_done
    alu_done = 1'b0;
    issue(16'h2100, 1'b0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("tmo_exec", {13'd0, busy, err, Load}, 16'd4);
    end
    @(negedge clk);
    chk("tmo_expired", {13'd0, instr_ready, err, Load}, 16'd6);
    @(negedge clk);
    chk("tmo_sticky", {15'd0, err}, 16'd1);
    #2 Clear_n = 1'b0;
    #1 chk("tmo_err_rst", {15'd0, err}, 16'd0);
    @(negedge clk);
    Clear_n = 1'b1;

    // alu_done on the final EXEC cycle wins over the timeout
    issue(16'h2100, 1'b1);
    repeat (16) @(negedge clk);
    alu_done = 1'b1;
    @(negedge clk);
    chk("tmo_race_load", {14'd0, Load, err}, 16'd2);
    @(negedge clk);
    chk("tmo_race_idle", {14'd0, busy, err}, 16'd0);
`endif

    repeat (2) @(negedge clk);
    chk("sb_empty", 16'(sb_q.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
